// File: rtl/mc_control_fsm.sv
// Multi-cycle processor control FSM: Moore per-state datapath controls, memory
// wait timeout, illegal-opcode trap and a retired-instruction counter.
module mc_control_fsm #(
    parameter int MEM_TIMEOUT = 16,
    parameter bit EN_JUMP     = 1'b1,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       op,
    input  logic             mem_ready,
    input  logic             trap_clr,
    output logic             mem_req,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic             branch,
    output logic             illegal,
    output logic             mem_fault,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       result_src,
    output logic [2:0]       imm_sel,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMREAD  = 4'd3,
        S_MEMWB   = 4'd4,  S_MEMWRITE = 4'd5, S_EXEC_R = 4'd6, S_EXEC_I   = 4'd7,
        S_ALUWB   = 4'd8,  S_BRANCH = 4'd9,  S_JUMP   = 4'd10, S_UPPER    = 4'd11,
        S_TRAP    = 4'd12
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_e            state_q, state_d;
    logic [6:0]        op_q, op_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  instret_q, instret_d;
    logic              illegal_q, illegal_d;
    logic              fault_q, fault_d;
    logic              active_q;
    logic              timeout;

    function automatic logic [2:0] imm_of(input logic [6:0] o);
        case (o)
            OP_I, OP_LOAD, OP_JALR: imm_of = 3'b001;
            OP_STORE:               imm_of = 3'b010;
            OP_BRANCH:              imm_of = 3'b011;
            OP_LUI, OP_AUIPC:       imm_of = 3'b100;
            OP_JAL:                 imm_of = 3'b101;
            default:                imm_of = 3'b000;
        endcase
    endfunction

    // A ready in the last allowed wait cycle still completes normally.
    assign timeout = (MEM_TIMEOUT > 0) && (wait_q == WAIT_LAST) && !mem_ready;

    assign state     = state_q;
    assign instret   = instret_q;
    assign illegal   = illegal_q;
    assign mem_fault = fault_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            op_q      <= '0;
            wait_q    <= '0;
            instret_q <= '0;
            illegal_q <= 1'b0;
            fault_q   <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
            illegal_q <= illegal_d;
            fault_q   <= fault_d;
            active_q  <= 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        illegal_d  = illegal_q;
        fault_d    = fault_q;
        wait_d     = wait_q;
        instret_d  = instret_q;
        mem_req    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        branch     = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        result_src = 2'b00;
        imm_sel    = 3'b000;

        // Strobes stay low until the first edge after reset release.
        if (active_q) begin
            case (state_q)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    mem_read  = 1'b1;
                    alu_src_b = 2'b10;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = S_DECODE;
                    end else if (timeout) begin
                        fault_d = 1'b1;
                        state_d = S_TRAP;
                    end
                end
                S_DECODE: begin
                    op_d      = op;
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                    imm_sel   = imm_of(op);
                    case (op)
                        OP_LOAD, OP_STORE: state_d = S_MEMADR;
                        OP_R:              state_d = S_EXEC_R;
                        OP_I:              state_d = S_EXEC_I;
                        OP_BRANCH:         state_d = S_BRANCH;
                        OP_JAL, OP_JALR: begin
                            if (EN_JUMP) state_d = S_JUMP;
                            else begin
                                state_d   = S_TRAP;
                                illegal_d = 1'b1;
                            end
                        end
                        OP_LUI, OP_AUIPC: begin
                            if (EN_JUMP) state_d = S_UPPER;
                            else begin
                                state_d   = S_TRAP;
                                illegal_d = 1'b1;
                            end
                        end
                        default: begin
                            state_d   = S_TRAP;
                            illegal_d = 1'b1;
                        end
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    imm_sel   = imm_of(op_q);
                    state_d   = (op_q == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
                end
                S_MEMREAD: begin
                    mem_req  = 1'b1;
                    mem_read = 1'b1;
                    if (mem_ready) state_d = S_MEMWB;
                    else if (timeout) begin
                        fault_d = 1'b1;
                        state_d = S_TRAP;
                    end
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    result_src = 2'b01;
                    state_d    = S_FETCH;
                end
                S_MEMWRITE: begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    if (mem_ready) state_d = S_FETCH;
                    else if (timeout) begin
                        fault_d = 1'b1;
                        state_d = S_TRAP;
                    end
                end
                S_EXEC_R: begin
                    alu_src_a = 2'b10;
                    alu_op    = 2'b10;
                    state_d   = S_ALUWB;
                end
                S_EXEC_I: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    alu_op    = 2'b10;
                    imm_sel   = imm_of(op_q);
                    state_d   = S_ALUWB;
                end
                S_ALUWB: begin
                    reg_write = 1'b1;
                    state_d   = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a = 2'b10;
                    alu_op    = 2'b01;
                    branch    = 1'b1;
                    state_d   = S_FETCH;
                end
                S_JUMP: begin
                    reg_write  = 1'b1;
                    pc_write   = 1'b1;
                    result_src = 2'b10;
                    alu_src_b  = 2'b01;
                    alu_src_a  = (op_q == OP_JALR) ? 2'b10 : 2'b01;
                    imm_sel    = imm_of(op_q);
                    state_d    = S_FETCH;
                end
                S_UPPER: begin
                    alu_src_b = 2'b01;
                    alu_src_a = (op_q == OP_LUI) ? 2'b11 : 2'b01;
                    imm_sel   = imm_of(op_q);
                    state_d   = S_ALUWB;
                end
                S_TRAP: begin
                    if (trap_clr) begin
                        illegal_d = 1'b0;
                        fault_d   = 1'b0;
                        state_d   = S_FETCH;
                    end
                end
                default: state_d = S_TRAP;
            endcase
        end

        if (state_d != state_q) wait_d = '0;
        else if (mem_req && !mem_ready) wait_d = wait_q + WAIT_W'(1);

        if (state_d == S_FETCH &&
            state_q inside {S_MEMWB, S_MEMWRITE, S_ALUWB, S_BRANCH, S_JUMP})
            instret_d = instret_q + CNT_W'(1);
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: per-instruction state schedules built from opcode
// class and memory delays, compared cycle by cycle against two DUT variants.
module tb_mc_control_fsm;

    localparam int TO = 4;
    localparam int CW = 4;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [6:0] op = '0;
    logic mem_ready = 1'b0;
    logic trap_clr = 1'b0;

    logic mem_req, mem_read, mem_write, ir_write, pc_write, reg_write, branch, illegal, mem_fault;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
    logic [2:0] imm_sel;
    logic [3:0] state;
    logic [CW-1:0] instret;

    logic n_mem_req, n_mem_read, n_mem_write, n_ir_write, n_pc_write, n_reg_write, n_branch;
    logic n_illegal, n_mem_fault;
    logic [1:0] n_alu_src_a, n_alu_src_b, n_alu_op, n_result_src;
    logic [2:0] n_imm_sel;
    logic [3:0] n_state;
    logic [CW-1:0] n_instret;

    int checks = 0;
    int errors = 0;
    int exp_ret = 0;

    typedef struct {
        int st;
        bit rdy;
        bit clr;
        bit ill;
        bit flt;
    } cyc_t;
    cyc_t sched[$];

    logic [19:0] act;
    assign act = {mem_req, mem_read, mem_write, ir_write, pc_write, reg_write, branch,
                  illegal, mem_fault, alu_src_a, alu_src_b, alu_op, result_src, imm_sel};

    always #5 clk = ~clk;

    mc_control_fsm #(.MEM_TIMEOUT(TO), .EN_JUMP(1'b1), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready), .trap_clr(trap_clr),
        .mem_req(mem_req), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .pc_write(pc_write), .reg_write(reg_write), .branch(branch), .illegal(illegal),
        .mem_fault(mem_fault), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .result_src(result_src), .imm_sel(imm_sel), .state(state), .instret(instret)
    );

    mc_control_fsm #(.MEM_TIMEOUT(0), .EN_JUMP(1'b0), .CNT_W(CW)) dut_nj (
        .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready), .trap_clr(trap_clr),
        .mem_req(n_mem_req), .mem_read(n_mem_read), .mem_write(n_mem_write),
        .ir_write(n_ir_write), .pc_write(n_pc_write), .reg_write(n_reg_write),
        .branch(n_branch), .illegal(n_illegal), .mem_fault(n_mem_fault),
        .alu_src_a(n_alu_src_a), .alu_src_b(n_alu_src_b), .alu_op(n_alu_op),
        .result_src(n_result_src), .imm_sel(n_imm_sel), .state(n_state), .instret(n_instret)
    );

    function automatic logic [2:0] imm_tab(input logic [6:0] o);
        if (o == OP_I || o == OP_LOAD || o == OP_JALR) return 3'b001;
        if (o == OP_STORE) return 3'b010;
        if (o == OP_BR) return 3'b011;
        if (o == OP_LUI || o == OP_AUIPC) return 3'b100;
        if (o == OP_JAL) return 3'b101;
        return 3'b000;
    endfunction

    // Expected control word for one cycle of a given state of instruction o.
    function automatic logic [19:0] spec_out(input int st, input logic [6:0] o, input bit rdy,
                                             input bit ill, input bit flt);
        logic mreq, mrd, mwr, irw, pcw, rw, br;
        logic [1:0] sa, sb, ao, rs;
        logic [2:0] im;
        {mreq, mrd, mwr, irw, pcw, rw, br} = '0;
        sa = 2'b00; sb = 2'b00; ao = 2'b00; rs = 2'b00; im = 3'b000;
        case (st)
            0:  begin mreq = 1; mrd = 1; sb = 2'b10; irw = rdy; pcw = rdy; end
            1:  begin sa = 2'b01; sb = 2'b01; im = imm_tab(o); end
            2:  begin sa = 2'b10; sb = 2'b01; im = imm_tab(o); end
            3:  begin mreq = 1; mrd = 1; end
            4:  begin rw = 1; rs = 2'b01; end
            5:  begin mreq = 1; mwr = 1; end
            6:  begin sa = 2'b10; ao = 2'b10; end
            7:  begin sa = 2'b10; sb = 2'b01; ao = 2'b10; im = imm_tab(o); end
            8:  rw = 1;
            9:  begin sa = 2'b10; ao = 2'b01; br = 1; end
            10: begin rw = 1; pcw = 1; rs = 2'b10; sb = 2'b01; im = imm_tab(o);
                      sa = (o == OP_JALR) ? 2'b10 : 2'b01; end
            11: begin sb = 2'b01; im = imm_tab(o); sa = (o == OP_LUI) ? 2'b11 : 2'b01; end
            default: ;
        endcase
        return {mreq, mrd, mwr, irw, pcw, rw, br, ill, flt, sa, sb, ao, rs, im};
    endfunction

    task automatic add(input int st, input bit rdy, input bit clr, input bit ill, input bit flt);
        cyc_t c;
        c.st = st; c.rdy = rdy; c.clr = clr; c.ill = ill; c.flt = flt;
        sched.push_back(c);
    endtask

    task automatic add_trap(input bit ill, input bit flt, input int td);
        repeat (td) add(12, 0, 0, ill, flt);
        add(12, 0, 1, ill, flt);
    endtask

    // A memory phase answered after d idle cycles, or a fault once TO idle cycles pass.
    task automatic add_mem(input int st, input int d, input int td, output bit ok);
        if (d >= TO) begin
            repeat (TO) add(st, 0, 0, 0, 0);
            add_trap(0, 1, td);
            ok = 0;
        end else begin
            repeat (d) add(st, 0, 0, 0, 0);
            add(st, 1, 0, 0, 0);
            ok = 1;
        end
    endtask

    task automatic run_instr(input string tag, input logic [6:0] opc, input int fd,
                             input int md, input int td);
        bit ok, ret;
        cyc_t c;
        sched.delete();
        ret = 0;
        add_mem(0, fd, td, ok);
        if (ok) begin
            add(1, 0, 0, 0, 0);
            if (opc == OP_LOAD) begin
                add(2, 0, 0, 0, 0); add_mem(3, md, td, ok);
                if (ok) begin add(4, 0, 0, 0, 0); ret = 1; end
            end else if (opc == OP_STORE) begin
                add(2, 0, 0, 0, 0); add_mem(5, md, td, ok); ret = ok;
            end else if (opc == OP_R) begin
                add(6, 0, 0, 0, 0); add(8, 0, 0, 0, 0); ret = 1;
            end else if (opc == OP_I) begin
                add(7, 0, 0, 0, 0); add(8, 0, 0, 0, 0); ret = 1;
            end else if (opc == OP_BR) begin
                add(9, 0, 0, 0, 0); ret = 1;
            end else if (opc == OP_JAL || opc == OP_JALR) begin
                add(10, 0, 0, 0, 0); ret = 1;
            end else if (opc == OP_LUI || opc == OP_AUIPC) begin
                add(11, 0, 0, 0, 0); add(8, 0, 0, 0, 0); ret = 1;
            end else begin
                add_trap(1, 0, td);
            end
        end
        for (int i = 0; i < sched.size(); i++) begin
            c = sched[i];
            op        = (c.st == 1) ? opc : 7'($urandom);
            mem_ready = (c.st == 0 || c.st == 3 || c.st == 5) ? c.rdy : 1'($urandom);
            trap_clr  = (c.st == 12) ? c.clr : 1'($urandom);
            @(negedge clk);
            checks++;
            if (state !== 4'(c.st)) begin
                errors++;
                $display("FAIL %s state cyc %0d op %b: got %0d want %0d", tag, i, opc, state, c.st);
            end
            checks++;
            if (act !== spec_out(c.st, opc, c.rdy, c.ill, c.flt)) begin
                errors++;
                $display("FAIL %s outputs cyc %0d st %0d op %b: got %h want %h", tag, i, c.st,
                         opc, act, spec_out(c.st, opc, c.rdy, c.ill, c.flt));
            end
            checks++;
            if (instret !== CW'(exp_ret)) begin
                errors++;
                $display("FAIL %s instret cyc %0d: got %0d want %0d", tag, i, instret, exp_ret);
            end
            @(posedge clk); #1;
        end
        if (ret) exp_ret = (exp_ret + 1) % (1 << CW);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        exp_ret = 0;
    endtask

    task automatic test_reset();
        op = OP_R; mem_ready = 1'b1; trap_clr = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (state !== 4'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
        checks++;
        if (act !== 20'h0) begin errors++; $display("FAIL reset_outputs got %h want 00000", act); end
        checks++;
        if (instret !== '0) begin errors++; $display("FAIL reset_instret got %0d want 0", instret); end
        rst_n = 1'b1;
        #1;
        checks++;
        if (act !== 20'h0) begin errors++; $display("FAIL reset_release got %h want 00000", act); end
        @(posedge clk); #1;
        exp_ret = 0;
    endtask

    task automatic test_r_type();
        run_instr("r_type", OP_R, 0, 0, 0);
    endtask

    task automatic test_load_wait();
        run_instr("load_wait", OP_LOAD, 0, 3, 0);
        run_instr("fetch_wait3", OP_I, 3, 0, 0);
    endtask

    task automatic test_timeout();
        run_instr("fetch_timeout", OP_R, 7, 0, 2);
        run_instr("write_timeout", OP_STORE, 0, 4, 0);
        run_instr("read_timeout", OP_LOAD, 1, 5, 1);
    endtask

    task automatic test_reset_midwrite();
        op = OP_STORE; mem_ready = 1'b1; trap_clr = 1'b0;
        repeat (3) begin @(negedge clk); @(posedge clk); #1; end
        mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (state !== 4'd5 || mem_write !== 1'b1) begin
            errors++; $display("FAIL midwrite_pre got st %0d wr %b want 5 1", state, mem_write);
        end
        checks++;
        if (instret !== CW'(exp_ret)) begin
            errors++; $display("FAIL midwrite_pre_instret got %0d want %0d", instret, exp_ret);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (state !== 4'd0 || mem_write !== 1'b0 || mem_fault !== 1'b0) begin
            errors++;
            $display("FAIL midwrite_reset got st %0d wr %b flt %b want 0 0 0", state, mem_write, mem_fault);
        end
        checks++;
        if (instret !== '0) begin errors++; $display("FAIL midwrite_instret got %0d want 0", instret); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        exp_ret = 0;
    endtask

    task automatic test_en_jump();
        op = OP_JAL; mem_ready = 1'b1; trap_clr = 1'b0;
        @(negedge clk); @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (state !== 4'd1 || n_state !== 4'd1) begin
            errors++; $display("FAIL jump_decode got %0d/%0d want 1/1", state, n_state);
        end
        @(posedge clk); #1;
        op = 7'($urandom);
        @(negedge clk);
        checks++;
        if ({state, pc_write, reg_write, result_src} !== {4'd10, 1'b1, 1'b1, 2'b10}) begin
            errors++;
            $display("FAIL jump_en got st %0d pcw %b rw %b rs %b want 10 1 1 10", state,
                     pc_write, reg_write, result_src);
        end
        checks++;
        if (n_state !== 4'd12 || n_illegal !== 1'b1 || n_reg_write !== 1'b0) begin
            errors++;
            $display("FAIL jump_dis got st %0d ill %b rw %b want 12 1 0", n_state, n_illegal, n_reg_write);
        end
        @(posedge clk); #1;
        trap_clr = 1'b1;
        @(negedge clk);
        checks++;
        if (instret !== CW'(1) || n_instret !== '0) begin
            errors++; $display("FAIL jump_instret got %0d/%0d want 1/0", instret, n_instret);
        end
        @(posedge clk); #1;
        trap_clr = 1'b0;
        @(negedge clk);
        checks++;
        if (n_state !== 4'd0 || n_illegal !== 1'b0) begin
            errors++; $display("FAIL jump_dis_clr got st %0d ill %b want 0 0", n_state, n_illegal);
        end
        do_reset();
    endtask

    task automatic test_random();
        logic [6:0] ops [9];
        logic [6:0] o;
        int k;
        ops = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
        for (int n = 0; n < 90; n++) begin
            k = $urandom_range(0, 9);
            o = (k == 9) ? 7'($urandom) : ops[k];
            run_instr("random", o, $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 2));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_r_type();
        test_load_wait();
        test_timeout();
        test_reset_midwrite();
        test_en_jump();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16: memory wait-cycle limit before fault; 0 disables the timeout.
REQ-002 Parameter EN_JUMP, default 1: 1 decodes JAL/JALR/LUI/AUIPC; 0 traps them as illegal.
REQ-003 Parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-004 Port: clk  in  1  single clock; all state changes on its rising edge.
REQ-005 Port: rst_n  in  1  asynchronous active-low reset.
REQ-006 Port: op  in  7  opcode from instruction register; valid only in DECODE.
REQ-007 Port: mem_ready  in  1  memory completes the current request this cycle.
REQ-008 Port: trap_clr  in  1  leaves TRAP.
REQ-009 Port outputs, 1 bit each: mem_req, mem_read, mem_write, ir_write, pc_write, reg_write, branch, illegal, mem_fault.
REQ-010 Port outputs, 2 bits each: alu_src_a (00 PC, 01 old PC, 10 rs1, 11 zero), alu_src_b (00 rs2, 01 imm, 10 const 4), alu_op (00 add, 01 branch compare, 10 funct decode), result_src (00 ALU, 01 mem data, 10 PC+4).
REQ-011 Port outputs, wider: imm_sel 3 bits (001 I, 010 S, 011 B, 100 U, 101 J, 000 none); state 4 bits; instret CNT_W bits.

Function
REQ-012 Moore FSM; state codes: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXEC_R 6, EXEC_I 7, ALUWB 8, BRANCH 9, JUMP 10, UPPER 11, TRAP 12; codes 13-15 go to TRAP.
REQ-013 All outputs not listed for a state SHALL be 0.
REQ-014 FETCH: mem_req=mem_read=1, src_a 00, src_b 10, alu_op 00; ir_write=pc_write=1 only in the mem_ready cycle; on mem_ready go to DECODE.
REQ-015 DECODE: op registered into op_q; src_a 01, src_b 01, alu_op 00; imm_sel from op: 0010011/0000011/1100111 -> 001, 0100011 -> 010, 1100011 -> 011, 0110111/0010111 -> 100, 1101111 -> 101.
REQ-016 DECODE next state: load/store -> MEMADR; 0110011 -> EXEC_R; 0010011 -> EXEC_I; 1100011 -> BRANCH; JAL/JALR -> JUMP and LUI/AUIPC -> UPPER when EN_JUMP=1; any other op -> TRAP with illegal=1.
REQ-017 In every later state, imm_sel and source selection derive from op_q, not op.
REQ-018 MEMADR: src_a 10, src_b 01, alu_op 00; load -> MEMREAD, store -> MEMWRITE.
REQ-019 MEMREAD: mem_req=mem_read=1; on mem_ready -> MEMWB.
REQ-020 MEMWB: reg_write=1, result_src 01 -> FETCH.
REQ-021 MEMWRITE: mem_req=mem_write=1; on mem_ready -> FETCH.
REQ-022 EXEC_R: src_a 10, src_b 00, alu_op 10. EXEC_I: src_a 10, src_b 01, alu_op 10. Both -> ALUWB.
REQ-023 ALUWB: reg_write=1, result_src 00 -> FETCH.
REQ-024 BRANCH: src_a 10, src_b 00, alu_op 01, branch=1 -> FETCH.
REQ-025 JUMP: reg_write=pc_write=1, result_src 10, src_b 01, src_a 01 (JAL) or 10 (JALR) -> FETCH.
REQ-026 UPPER: src_b 01, alu_op 00, src_a 11 (LUI) or 01 (AUIPC) -> ALUWB.
REQ-027 TRAP: all strobes 0; illegal or mem_fault held; trap_clr=1 -> FETCH, clearing both flags.
REQ-028 Wait counter: cleared on entry to FETCH/MEMREAD/MEMWRITE; increments each cycle mem_req=1 and mem_ready=0.
REQ-029 Timeout: with MEM_TIMEOUT>0, counter==MEM_TIMEOUT-1 and mem_ready=0 -> TRAP with mem_fault=1; mem_ready in that same cycle wins (normal transition).
REQ-030 instret increments by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB, BRANCH or JUMP; never from TRAP; wraps at 2^CNT_W.

Reset
REQ-031 rst_n low SHALL immediately force state=FETCH, instret=0, op_q=0, wait counter=0, illegal=mem_fault=0, and hold all strobes at 0.
REQ-032 After rst_n deasserts, FETCH outputs take effect from the next cycle; reset mid-request abandons the request without a fault.

Verification
REQ-033 R-type add, mem_ready=1 in FETCH: states 0,1,6,8,0; reg_write=1 only in ALUWB; instret 0->1.
REQ-034 Load with mem_ready delayed 3 cycles in MEMREAD: states 0,1,2,3,3,3,3,4,0; mem_req held high throughout MEMREAD; no fault.
REQ-035 MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH: TRAP entered after 4 FETCH cycles with mem_fault=1; trap_clr -> FETCH; instret unchanged.
REQ-036 EN_JUMP=0 with op=1101111: DECODE -> TRAP, illegal=1; with EN_JUMP=1: DECODE -> JUMP, pc_write=reg_write=1, result_src=10.
REQ-037 rst_n pulsed low during MEMWRITE: state=0, mem_write=0 asynchronously, instret=0.
